bitwise_logic_unit: RTL



---
 rtl/bitwise_logic_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bitwise_logic_unit.sv
// Slice-serial bitwise logic unit: eight ops, SLICE bits per cycle, valid/ready on both sides.
// Optional all_ones/parity reduction flags are built in when BWLU_REDUCE_EN is defined.
module bitwise_logic_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef BWLU_REDUCE_EN
    output logic             all_ones,
    output logic             parity,
`endif
    output logic             zero
);

    localparam int unsigned NSL = WIDTH / SLICE;
    localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e                       state_q, state_d;
    logic [NSL-1:0][SLICE-1:0]    a_q, a_d;
    logic [NSL-1:0][SLICE-1:0]    b_q, b_d;
    logic [NSL-1:0][SLICE-1:0]    s_q, s_d;
    logic [2:0]                   op_q, op_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         nz_q, nz_d;
    logic                         zero_q, zero_d;
    logic [SLICE-1:0]             a_sl, b_sl, res_sl;
    logic                         last;
`ifdef BWLU_REDUCE_EN
    logic                         and_q, and_d;
    logic                         xor_q, xor_d;
    logic                         all_ones_q, all_ones_d;
    logic                         parity_q, parity_d;
`endif

    // Select the operand slice addressed by cnt; a compare loop stays legal for NSL == 1.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSL; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[i];
                b_sl = b_q[i];
            end
        end
    end

    always_comb begin
        res_sl = '0;
        unique case (op_q)
            3'b000: res_sl = a_sl & b_sl;
            3'b001: res_sl = a_sl | b_sl;
            3'b010: res_sl = a_sl ^ b_sl;
            3'b011: res_sl = ~(a_sl & b_sl);
            3'b100: res_sl = ~(a_sl | b_sl);
            3'b101: res_sl = ~(a_sl ^ b_sl);
            3'b110: res_sl = a_sl & ~b_sl;
            3'b111: res_sl = a_sl;
            default: res_sl = '0;
        endcase
    end

    assign last = (cnt_q == CW'(NSL - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        nz_d    = nz_q;
        zero_d  = zero_q;
`ifdef BWLU_REDUCE_EN
        and_d      = and_q;
        xor_d      = xor_q;
        all_ones_d = all_ones_q;
        parity_d   = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    s_d     = '0;
                    cnt_d   = '0;
                    nz_d    = 1'b0;
`ifdef BWLU_REDUCE_EN
                    and_d   = 1'b1;
                    xor_d   = 1'b0;
`endif
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int i = 0; i < NSL; i++) begin
                    if (cnt_q == CW'(i)) s_d[i] = res_sl;
                end
                nz_d = nz_q | (|res_sl);
`ifdef BWLU_REDUCE_EN
                and_d = and_q & (&res_sl);
                xor_d = xor_q ^ (^res_sl);
`endif
                if (last) begin
                    // Flags are captured from the accumulators including the final slice.
                    cnt_d   = '0;
                    zero_d  = ~nz_d;
`ifdef BWLU_REDUCE_EN
                    all_ones_d = and_d;
                    parity_d   = xor_d;
`endif
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            nz_q    <= 1'b0;
            zero_q  <= 1'b0;
`ifdef BWLU_REDUCE_EN
            and_q      <= 1'b0;
            xor_q      <= 1'b0;
            all_ones_q <= 1'b0;
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            nz_q    <= nz_d;
            zero_q  <= zero_d;
`ifdef BWLU_REDUCE_EN
            and_q      <= and_d;
            xor_q      <= xor_d;
            all_ones_q <= all_ones_d;
            parity_q   <= parity_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign zero      = zero_q;
`ifdef BWLU_REDUCE_EN
    assign all_ones  = all_ones_q;
    assign parity    = parity_q;
`endif

endmodule
